// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment scan controller.
//   seg_t        : 7-bit segment vector {g,f,e,d,c,b,a}, active-low
//   SEG_BLANK    : all segments off
//   SEG_INVALID  : pattern shown for a nibble that is not a clean 0..F
//   SEG_TABLE    : hex 0..F to active-low segment patterns
// ---------------------------------------------------------------------------
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK   = 7'h7F;
    localparam seg_t SEG_INVALID = 7'h3F;

    localparam seg_t SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// ---------------------------------------------------------------------------
// seg7_hex_decode
// Purely combinational hex nibble to active-low seven-segment decoder.
// Ports:
//   nibble : in  4 bits, hex digit to display
//   seg    : out 7 bits, {g,f,e,d,c,b,a}, active-low
// A nibble that matches no table entry (X/Z in simulation) gives SEG_INVALID.
// ---------------------------------------------------------------------------
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_INVALID;
        case (nibble)
            4'h0: seg = SEG_TABLE[0];
            4'h1: seg = SEG_TABLE[1];
            4'h2: seg = SEG_TABLE[2];
            4'h3: seg = SEG_TABLE[3];
            4'h4: seg = SEG_TABLE[4];
            4'h5: seg = SEG_TABLE[5];
            4'h6: seg = SEG_TABLE[6];
            4'h7: seg = SEG_TABLE[7];
            4'h8: seg = SEG_TABLE[8];
            4'h9: seg = SEG_TABLE[9];
            4'hA: seg = SEG_TABLE[10];
            4'hB: seg = SEG_TABLE[11];
            4'hC: seg = SEG_TABLE[12];
            4'hD: seg = SEG_TABLE[13];
            4'hE: seg = SEG_TABLE[14];
            4'hF: seg = SEG_TABLE[15];
            default: seg = SEG_INVALID;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
// Time-multiplexed driver for an N-digit common-anode seven-segment bank.
// A hex word arrives over valid/ready, waits in a pending buffer and is
// committed to the shown word only at a frame boundary, so the bank never
// displays half of one word and half of another.
//
// Parameters:
//   N_DIGITS : digits in the bank (1..8)
//   DWELL    : clock cycles each digit stays lit (>= 2)
// Ports:
//   clk        : in  system clock
//   rst_n      : in  synchronous active-low reset
//   en         : in  scan enable; low blanks the bank and freezes the scan
//   in_valid   : in  new display word offered
//   in_data    : in  4*N_DIGITS hex word, nibble i -> digit i (0 rightmost)
//   in_ready   : out pending buffer empty
//   an         : out N_DIGITS anode selects, active-low
//   seg        : out 7 segments {g,f,e,d,c,b,a}, active-low
//   frame_done : out one-cycle pulse after the last digit's dwell ends
// Build option:
//   SEG7_SCAN_BLANK_LZ_EN : when defined, digits above the most significant
//                           nonzero nibble are blanked (digit 0 never is).
// ---------------------------------------------------------------------------
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter  int N_DIGITS = 8,
    parameter  int DWELL    = 50000,
    localparam int CNT_W    = $clog2(DWELL)
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [4*N_DIGITS-1:0] in_data,
    output logic                  in_ready,
    output logic [N_DIGITS-1:0]   an,
    output seg_t                  seg,
    output logic                  frame_done
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [4*N_DIGITS-1:0] shown_q, shown_d;
    logic [4*N_DIGITS-1:0] pend_q, pend_d;
    logic                  pend_full_q, pend_full_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    seg_t                  seg_q, seg_d;
    logic                  frame_done_q, frame_done_d;

    logic                  xfer;
    logic                  wrap;
    logic                  frame_end;
    logic [3:0]            nibble;
    seg_t                  dec_seg;
    logic                  lz_blank;

    // Select the nibble of the shown word belonging to the current digit
    always_comb begin
        nibble = 4'h0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nibble = shown_q[4*i +: 4];
            end
        end
    end

    seg7_hex_decode u_decode (
        .nibble (nibble),
        .seg    (dec_seg)
    );

`ifdef SEG7_SCAN_BLANK_LZ_EN
    logic [IDX_W-1:0] top_nz;

    // Highest digit holding a nonzero nibble; stays 0 for an all-zero word
    // so digit 0 always shows
    always_comb begin
        top_nz = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (shown_q[4*i +: 4] != 4'h0) begin
                top_nz = IDX_W'(i);
            end
        end
    end

    assign lz_blank = (idx_q > top_nz);
`else
    assign lz_blank = 1'b0;
`endif

    // Prescaler, digit index, handshake/commit and registered pin drive
    always_comb begin
        xfer      = in_valid && !pend_full_q;
        wrap      = en && (cnt_q == CNT_W'(DWELL - 1));
        frame_end = wrap && (idx_q == IDX_W'(N_DIGITS - 1));

        shown_d      = shown_q;
        pend_d       = pend_q;
        pend_full_d  = pend_full_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        frame_done_d = frame_end;
        an_d         = '1;
        seg_d        = SEG_BLANK;

        if (en) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (wrap) begin
                idx_d = frame_end ? '0 : idx_q + 1'b1;
            end
        end

        // A full pending buffer blocks xfer, so the bypass branch can only
        // be reached with pending empty
        if (frame_end && pend_full_q) begin
            shown_d     = pend_q;
            pend_full_d = 1'b0;
        end else if (frame_end && xfer) begin
            shown_d = in_data;
        end else if (xfer) begin
            pend_d      = in_data;
            pend_full_d = 1'b1;
        end

        if (en) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                an_d[i] = (idx_q != IDX_W'(i));
            end
            seg_d = lz_blank ? SEG_BLANK : dec_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shown_q      <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            idx_q        <= '0;
            cnt_q        <= '0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            frame_done_q <= 1'b0;
        end else begin
            shown_q      <= shown_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in_ready   = !pend_full_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Self-checking bench for seg7_scan_ctrl with N_DIGITS=4, DWELL=4.
// Expected scan outputs are queued frame by frame and popped one per clock.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

    localparam int N_DIGITS = 4;
    localparam int DWELL    = 4;
    localparam int FRAME    = N_DIGITS * DWELL;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    int scanNum  = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
        logic       rdy;
    } sb_entry_t;

    typedef struct packed {
        logic [15:0]     word;
        logic [3:0][6:0] segs;
    } vec_t;

    sb_entry_t sbQ[$];
    vec_t      vecs[4];

    seg7_scan_ctrl #(
        .N_DIGITS (N_DIGITS),
        .DWELL    (DWELL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    // Hex-to-segment reference, written from the display table
    function automatic logic [6:0] hexSeg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Expected segment pattern per digit for a shown word
    function automatic logic [3:0][6:0] segsOf(input logic [15:0] w);
        logic [3:0][6:0] s;
        logic            leading;
        for (int d = 0; d < 4; d++) s[d] = hexSeg(w[4*d +: 4]);
        leading = 1'b1;
        for (int d = 3; d >= 1; d--) begin
            if (w[4*d +: 4] != 4'h0) leading = 1'b0;
`ifdef SEG7_SCAN_BLANK_LZ_EN
            if (leading) s[d] = 7'h7F;
`endif
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic e);
        in_valid = v;
        in_data  = d;
        en       = e;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] expAn,
                               input logic [6:0] expSeg, input logic expFd,
                               input logic expRdy);
        checks++;
        if ({an, seg, frame_done, in_ready} !== {expAn, expSeg, expFd, expRdy}) begin
            failures++;
            $display("[TB] FAIL %s: got an=%h seg=%h fd=%b rdy=%b, want an=%h seg=%h fd=%b rdy=%b",
                     name, an, seg, frame_done, in_ready, expAn, expSeg, expFd, expRdy);
        end
    endtask

    // Queue the expected outputs for frame positions first..last (1-based);
    // position p is the sample taken p edges after the previous frame end
    task automatic pushFrame(input logic [3:0][6:0] segs, input int first,
                             input int last, input logic rdyMid, input logic rdyEnd);
        sb_entry_t e;
        for (int p = first; p <= last; p++) begin
            int d;
            d     = (p - 1) / DWELL;
            e.an  = ~(4'b0001 << d);
            e.seg = segs[d];
            e.fd  = (p == FRAME);
            e.rdy = (p == FRAME) ? rdyEnd : rdyMid;
            sbQ.push_back(e);
        end
    endtask

    task automatic pushBlank(input int n);
        sb_entry_t e;
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.fd  = 1'b0;
        e.rdy = 1'b1;
        for (int k = 0; k < n; k++) sbQ.push_back(e);
    endtask

    task automatic drainQueue(input int n);
        sb_entry_t e;
        for (int k = 0; k < n; k++) begin
            tick();
            scanNum++;
            if (sbQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL scan%0d: scoreboard empty, got an=%h seg=%h", scanNum, an, seg);
            end else begin
                e = sbQ.pop_front();
                checkOutput($sformatf("scan%0d", scanNum), e.an, e.seg, e.fd, e.rdy);
            end
        end
    endtask

    // Advance until frame_done is sampled high, bounded by two frames
    task automatic waitFrameDone(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 2 * FRAME + 4; k++) begin
            tick();
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s: frame_done got 0 within budget, want 1", name);
        end
    endtask

    // Offer one word for a single cycle (caller ensures in_ready is high)
    task automatic loadWord(input logic [15:0] w);
        applyStimulus(1'b1, w, 1'b1);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b1);
    endtask

    initial begin
        vecs[0] = '{word: 16'h1234, segs: {7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{word: 16'h5678, segs: {7'h12, 7'h02, 7'h78, 7'h00}};
        vecs[2] = '{word: 16'h9ABC, segs: {7'h10, 7'h08, 7'h03, 7'h46}};
        vecs[3] = '{word: 16'hDEF0, segs: {7'h21, 7'h06, 7'h0E, 7'h40}};

        rst_n = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0);
        repeat (3) tick();
        checkOutput("reset_state", 4'hF, 7'h7F, 1'b0, 1'b1);
        rst_n = 1'b1;

        // Decode table through the full scan path, one word per vector
        for (int i = 0; i < 4; i++) begin
            loadWord(vecs[i].word);
            checkOutput($sformatf("vec%0d_accept", i), an, seg, frame_done, 1'b0);
            waitFrameDone($sformatf("vec%0d_commit", i));
            pushFrame(vecs[i].segs, 1, FRAME, 1'b1, 1'b1);
            drainQueue(FRAME);
        end

        // Reset mid-frame with a pending word: the word must be lost
        repeat (5) tick();
        loadWord(16'h7777);
        tick();
        rst_n = 1'b0;
        tick();
        checkOutput("reset_midframe", 4'hF, 7'h7F, 1'b0, 1'b1);
        rst_n = 1'b1;
        pushFrame(segsOf(16'h0000), 1, FRAME, 1'b1, 1'b1);
        pushFrame(segsOf(16'h0000), 1, FRAME, 1'b1, 1'b1);
        drainQueue(2 * FRAME);

        // Back-to-back offers: AAAA taken, 5555 held off to the frame end
        repeat (3) tick();
        applyStimulus(1'b1, 16'hAAAA, 1'b1);
        tick();
        checkOutput("b2b_first_accept", an, seg, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h5555, 1'b1);
        tick();
        checkOutput("b2b_second_held", an, seg, 1'b0, 1'b0);
        waitFrameDone("b2b_commit");
        checkOutput("b2b_ready_after_commit", an, seg, 1'b1, 1'b1);
        pushFrame(segsOf(16'hAAAA), 1, FRAME, 1'b0, 1'b1);
        drainQueue(FRAME);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        pushFrame(segsOf(16'h5555), 1, FRAME, 1'b1, 1'b1);
        drainQueue(FRAME);

        // Offer exactly on the frame-end edge with pending empty: bypass
        pushFrame(segsOf(16'h5555), 1, FRAME, 1'b1, 1'b1);
        drainQueue(FRAME - 1);
        applyStimulus(1'b1, 16'hBEEF, 1'b1);
        drainQueue(1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        pushFrame(segsOf(16'hBEEF), 1, FRAME, 1'b1, 1'b1);
        drainQueue(FRAME);

        // Scan frozen and blanked for 10 cycles during digit 2
        pushFrame(segsOf(16'hBEEF), 1, 9, 1'b1, 1'b1);
        pushBlank(10);
        pushFrame(segsOf(16'hBEEF), 10, FRAME, 1'b1, 1'b1);
        drainQueue(9);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        drainQueue(10);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        drainQueue(FRAME - 9);

        // Leading zeros (blanked only when the build option is on)
        loadWord(16'h0040);
        waitFrameDone("lz_0040_commit");
        pushFrame(segsOf(16'h0040), 1, FRAME, 1'b1, 1'b1);
        drainQueue(FRAME);
        loadWord(16'h0000);
        waitFrameDone("lz_0000_commit");
        pushFrame(segsOf(16'h0000), 1, FRAME, 1'b1, 1'b1);
        drainQueue(FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed driver for an N-digit common-anode seven-segment bank on the RISC-V board.
- Accepts a hex word over a valid/ready handshake and double-buffers it so the shown value changes only at frame boundaries (no tearing).
- Scans one digit at a time through a shared hex-to-segment decoder.
- Sits between the CPU's memory-mapped display register and the board pins.

Parameters:
- N_DIGITS, 8, digits in the bank; legal range 1..8.
- DWELL, 50000, clock cycles each digit stays lit; legal DWELL >= 2.
- CNT_W, $clog2(DWELL), prescaler width; derived, not overridden.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- en  in  1  scan enable; low blanks the bank and freezes the scan.
- in_valid  in  1  new display word offered.
- in_data  in  4*N_DIGITS  hex word; nibble i goes to digit i (digit 0 rightmost).
- in_ready  out  1  high when the pending buffer is empty.
- an  out  N_DIGITS  anode selects, active-low, one-hot-low while scanning.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- frame_done  out  1  one-cycle pulse when the last digit's dwell ends.

Behaviour:
- Reset (rst_n low at a rising edge):
  - shown=0, pending empty, digit index idx=0, prescaler=0.
  - an=all 1s, seg=7'h7F, in_ready=1, frame_done=0.
  - Reset mid-frame or mid-handshake discards the pending word.
- Prescaler: when en=1, counts 0..DWELL-1 and wraps to 0.
  - At wrap, idx increments.
  - At wrap with idx=N_DIGITS-1, idx goes to 0 and frame_done pulses on the same edge.
- Output timing: an and seg are registered, one cycle behind idx.
  - an[idx]=0, all other bits 1.
  - seg = decode(shown[4*idx+:4]).
- Decode table, hex 0..F:
  - 40, 79, 24, 30, 19, 12, 02, 78
  - 00, 10, 08, 03, 46, 21, 06, 0E
  - Any unknown nibble gives 3F.
- Handshake:
  - A transfer occurs on an edge where in_valid & in_ready.
  - The accepted word goes to pending and in_ready drops on the next cycle.
  - While in_ready=0, in_data is ignored.
- Commit: on the frame-end edge, if pending is full, pending moves to shown, pending empties and in_ready returns to 1.
- Simultaneous transfer and frame end with pending empty: the word bypasses straight into shown; in_ready stays 1.
- en=0:
  - an=all 1s and seg=7'h7F from the next cycle.
  - Prescaler and idx hold; no frame_done; no commit.
  - The handshake still accepts one word into pending.
- en rising: scan resumes from the held idx and prescaler.
- N_DIGITS=1: every wrap is a frame end.

Optional Feature:
- Macro: SEG7_SCAN_BLANK_LZ_EN.
- Defined: leading-zero blanking.
  - A digit whose index is above the most significant nonzero nibble of shown outputs seg=7'h7F; its anode is still driven low.
  - Digit 0 is never blanked, so shown=0 displays "0".
- Undefined: every digit is decoded, including leading zeros.

Decomposition:
- Package seg7_pkg holds:
  - SEG_BLANK=7'h7F and SEG_INVALID=7'h3F.
  - The 16-entry segment constant table.
  - A typedef for the 7-bit segment vector.
- One natural sub-module: seg7_hex_decode, purely combinational, 4-bit nibble to 7-bit segments per the table. It is instantiated once and muxed by idx.

Test Plan (N_DIGITS=4, DWELL=4 unless stated):
- Reset mid-scan with a pending word -> next cycle: an=4'hF, seg=7F, in_ready=1, frame_done=0. Following frame shows 0000.
- Load 16'h1234 after reset, en=1 -> committed at first frame end. Per 4-cycle dwell, (an,seg) = (E,19), (D,30), (B,24), (7,79). frame_done pulses once per 16 cycles.
- Two back-to-back valids, 16'hAAAA then 16'h5555, mid-frame -> first accepted and in_ready=0. 5555 is held off until the frame end. Bank shows AAAA next frame, then 5555.
- in_valid asserted exactly on the frame-end edge with pending empty -> 16'hBEEF is shown from digit 0 immediately; in_ready never drops.
- en low for 10 cycles mid-digit-2 -> an=F, seg=7F, no frame_done. On re-enable, digit 2 completes its remaining dwell.
- Macro defined, shown=16'h0040 -> digits 3 and 2 give seg=7F, digit 1 gives 19, digit 0 gives 40. shown=0 -> only digit 0 gives 40.
